alarm_unit: RTL and testbench
=============================

ALARM_UNIT -- requirements
Module: alarm_unit

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset; parameters and ports follow.
REQ-002 Parameter RING_SECS, default 60, SHALL set the number of tick pulses one ring period lasts.
REQ-003 Parameter SNOOZE_SECS, default 300, SHALL set the number of tick pulses one snooze period lasts.
REQ-004 Parameter BUZZ_HALF, default 25000, SHALL set the number of mclk cycles per half-period of the buzz tone.
REQ-005 Port mclk, in, 1: system clock.
REQ-006 Port rst, in, 1: asynchronous, active-low reset.
REQ-007 Port tick, in, 1: one-mclk-cycle pulse marking each timer seconds increment; the digit inputs already hold the new time in that cycle.
REQ-008 Ports h_1, h_0, m_1, m_0, s_1, s_0, in, 4 each: BCD time digits from the timer; hours range 00..11.
REQ-009 Port alarm_on, in, 1: level; alarm armed.
REQ-010 Port set_mode, in, 1: level; alarm-time edit mode.
REQ-011 Ports inc_h, inc_m, in, 1 each: one-cycle pulses that increment the alarm hour and minute.
REQ-012 Ports snooze and stop, in, 1 each: one-cycle pulses.
REQ-013 Ports al_h1, al_h0, al_m1, al_m0, out, 4 each: BCD alarm-time digits for display.
REQ-014 Ports ringing, snoozed and buzz, out, 1 each: in RING, in SNOOZE, and the tone output.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RING and SNOOZE, each with a distinct encoding.
REQ-016 Match SHALL be true when h_1:h_0:m_1:m_0 equals the alarm digits, s_1 = 0 and s_0 = 0.
REQ-017 IDLE->RING SHALL occur in the cycle after tick = 1 with match, alarm_on = 1 and set_mode = 0; entry SHALL clear the ring counter.
REQ-018 In RING, each tick SHALL increment the ring counter; on reaching RING_SECS -> IDLE.
REQ-019 In RING, snooze -> SNOOZE and SHALL clear the snooze counter.
REQ-020 In SNOOZE, each tick SHALL increment the snooze counter; on reaching SNOOZE_SECS -> RING with the ring counter cleared.
REQ-021 In RING or SNOOZE, stop, alarm_on = 0 or set_mode = 1 -> IDLE.
REQ-022 Priority among simultaneous events SHALL be: leave-to-IDLE (REQ-021) > snooze > counter timeout.
REQ-023 A snooze pulse in IDLE or SNOOZE SHALL be ignored.
REQ-024 A new match while in RING or SNOOZE SHALL NOT restart the counters.
REQ-025 Alarm digits SHALL change only while set_mode = 1.
REQ-026 inc_h SHALL step the alarm hour 00..11 in BCD and wrap 11->00.
REQ-027 inc_m SHALL step the alarm minute 00..59 in BCD and wrap 59->00 with no carry into hours.
REQ-028 inc_h and inc_m in the same cycle SHALL both apply.
REQ-029 ringing and snoozed SHALL be registered decodes of the state, valid one cycle after the transition.
REQ-030 The tone divider SHALL run only in RING, toggling its output every BUZZ_HALF mclk cycles, and SHALL be cleared outside RING.
REQ-031 buzz SHALL equal the tone output AND ringing; buzz = 0 in IDLE and SNOOZE.
REQ-032 Counters SHALL be wide enough for the maximum parameter values without overflow: ceil(log2(X+1)) bits.

Reset
REQ-033 While rst = 0, the block SHALL hold state IDLE, counters 0, alarm digits 00:00, and ringing = snoozed = buzz = 0.
REQ-034 Reset asserted mid-RING or mid-SNOOZE SHALL abort immediately (asynchronously) to the REQ-033 values.
REQ-035 After rst rises, the first transition SHALL be possible on the first mclk edge.

Configuration
REQ-036 With macro ALARM_SNOOZE_EN defined, snooze behaviour SHALL be as in REQ-019, REQ-020 and REQ-023.
REQ-037 Without ALARM_SNOOZE_EN, the snooze input SHALL be ignored, SNOOZE SHALL be unreachable, snoozed SHALL be constant 0, and no snooze counter SHALL be built.

Verification
REQ-038 Alarm 00:00, set_mode = 1, inc_h x13 and inc_m x61 -> al digits 01:01.
REQ-039 Alarm 07:30, alarm_on = 1, tick with time 07:30:00 -> ringing = 1 next cycle; buzz toggles every 25000 cycles; after 60 ticks -> ringing = 0.
REQ-040 RING, then snooze pulse -> snoozed = 1, buzz = 0; after 300 ticks -> ringing = 1 again (macro defined); with the macro undefined, ringing stays 1.
REQ-041 RING, with stop and snooze in the same cycle -> IDLE, with ringing = snoozed = 0.
REQ-042 rst = 0 mid-RING asynchronously -> all outputs 0 and alarm 00:00 without a clock edge.
REQ-043 Match tick with alarm_on = 0, or with set_mode = 1 -> state remains IDLE.

Source files
------------

// File: rtl/alarm_unit.sv
// alarm_unit: alarm-time register, IDLE/RING/SNOOZE controller and buzz tone divider.
// Snooze support is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_unit #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int BUZZ_HALF   = 25000
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] h_1,
    input  logic [3:0] h_0,
    input  logic [3:0] m_1,
    input  logic [3:0] m_0,
    input  logic [3:0] s_1,
    input  logic [3:0] s_0,
    input  logic       alarm_on,
    input  logic       set_mode,
    input  logic       inc_h,
    input  logic       inc_m,
    input  logic       snooze,
    input  logic       stop,
    output logic [3:0] al_h1,
    output logic [3:0] al_h0,
    output logic [3:0] al_m1,
    output logic [3:0] al_m0,
    output logic       ringing,
    output logic       snoozed,
    output logic       buzz
);

    localparam int RW = $clog2(RING_SECS + 1);
    localparam int BW = $clog2(BUZZ_HALF + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   ring_cnt, ring_cnt_nxt;
    logic [BW-1:0]   buzz_cnt;
    logic            tone;
    logic            match, leave, snooze_req, ring_done;
    logic [3:0]      ah1_n, ah0_n, am1_n, am0_n;

    assign match = ({h_1, h_0, m_1, m_0} == {al_h1, al_h0, al_m1, al_m0})
                   && (s_1 == 4'd0) && (s_0 == 4'd0);
    assign leave     = stop | ~alarm_on | set_mode;
    assign ring_done = (ring_cnt == RW'(RING_SECS - 1));

`ifdef ALARM_SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_SECS + 1);
    logic [SW-1:0] snz_cnt, snz_cnt_nxt;
    logic          snz_done;

    assign snooze_req = snooze;
    assign snz_done   = (snz_cnt == SW'(SNOOZE_SECS - 1));
`else
    logic unused_snooze;

    assign snooze_req    = 1'b0;
    assign unused_snooze = snooze;
`endif

    always_comb begin
        state_nxt    = state;
        ring_cnt_nxt = ring_cnt;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_nxt  = snz_cnt;
`endif
        case (state)
            IDLE: begin
                if (tick && match && alarm_on && !set_mode) begin
                    state_nxt    = RING;
                    ring_cnt_nxt = '0;
                end
            end
            RING: begin
                // leave beats snooze, snooze beats the ring timeout
                if (leave) begin
                    state_nxt    = IDLE;
                    ring_cnt_nxt = '0;
                end else if (snooze_req) begin
                    state_nxt = SNOOZE;
`ifdef ALARM_SNOOZE_EN
                    snz_cnt_nxt = '0;
`endif
                end else if (tick) begin
                    if (ring_done) begin
                        state_nxt    = IDLE;
                        ring_cnt_nxt = '0;
                    end else begin
                        ring_cnt_nxt = ring_cnt + RW'(1);
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (leave) begin
                    state_nxt   = IDLE;
                    snz_cnt_nxt = '0;
                end else if (tick) begin
                    if (snz_done) begin
                        state_nxt    = RING;
                        ring_cnt_nxt = '0;
                        snz_cnt_nxt  = '0;
                    end else begin
                        snz_cnt_nxt = snz_cnt + SW'(1);
                    end
                end
            end
`endif
            default: begin
                state_nxt    = IDLE;
                ring_cnt_nxt = '0;
            end
        endcase
    end

    // Status flags decode the next state so they line up with the state register.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ring_cnt <= '0;
            ringing  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ring_cnt <= ring_cnt_nxt;
            ringing  <= (state_nxt == RING);
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            snz_cnt <= '0;
            snoozed <= 1'b0;
        end else begin
            snz_cnt <= snz_cnt_nxt;
            snoozed <= (state_nxt == SNOOZE);
        end
    end
`else
    assign snoozed = 1'b0;
`endif

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            buzz_cnt <= '0;
            tone     <= 1'b0;
        end else if (state != RING) begin
            buzz_cnt <= '0;
            tone     <= 1'b0;
        end else if (buzz_cnt == BW'(BUZZ_HALF - 1)) begin
            buzz_cnt <= '0;
            tone     <= ~tone;
        end else begin
            buzz_cnt <= buzz_cnt + BW'(1);
        end
    end

    assign buzz = tone & ringing;

    // Hours run 00..11, minutes 00..59, each wrapping independently.
    always_comb begin
        ah1_n = al_h1;
        ah0_n = al_h0;
        am1_n = al_m1;
        am0_n = al_m0;
        if (set_mode && inc_h) begin
            if (al_h1 == 4'd1 && al_h0 == 4'd1) begin
                ah1_n = 4'd0;
                ah0_n = 4'd0;
            end else if (al_h0 == 4'd9) begin
                ah1_n = al_h1 + 4'd1;
                ah0_n = 4'd0;
            end else begin
                ah0_n = al_h0 + 4'd1;
            end
        end
        if (set_mode && inc_m) begin
            if (al_m0 == 4'd9) begin
                am0_n = 4'd0;
                am1_n = (al_m1 == 4'd5) ? 4'd0 : al_m1 + 4'd1;
            end else begin
                am0_n = al_m0 + 4'd1;
            end
        end
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            al_h1 <= 4'd0;
            al_h0 <= 4'd0;
            al_m1 <= 4'd0;
            al_m0 <= 4'd0;
        end else begin
            al_h1 <= ah1_n;
            al_h0 <= ah0_n;
            al_m1 <= am1_n;
            al_m0 <= am0_n;
        end
    end

endmodule

// File: tb/tb_alarm_unit.sv
// Testbench for alarm_unit: table-driven alarm editing plus scoreboarded ring/snooze sequences.
module tb_alarm_unit;
    localparam int RS = 6;
    localparam int SS = 4;
    localparam int BH = 5;

    logic       mclk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] h_1 = '0, h_0 = '0, m_1 = '0, m_0 = '0, s_1 = '0, s_0 = '0;
    logic       alarm_on = 1'b0, set_mode = 1'b0, inc_h = 1'b0, inc_m = 1'b0;
    logic       snooze = 1'b0, stop = 1'b0;
    logic [3:0] al_h1, al_h0, al_m1, al_m0;
    logic       ringing, snoozed, buzz;

    int errors = 0;
    int checks = 0;
    int mh = 0;
    int mm = 0;

    typedef struct {
        string       name;
        logic [15:0] al;
        logic        ring;
        logic        snz;
        int          bz;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        sm;
        logic        ih;
        logic        im;
        logic [15:0] al;
    } vec_t;
    vec_t tbl[5];

    alarm_unit #(.RING_SECS(RS), .SNOOZE_SECS(SS), .BUZZ_HALF(BH)) dut (
        .mclk(mclk), .rst(rst), .tick(tick),
        .h_1(h_1), .h_0(h_0), .m_1(m_1), .m_0(m_0), .s_1(s_1), .s_0(s_0),
        .alarm_on(alarm_on), .set_mode(set_mode), .inc_h(inc_h), .inc_m(inc_m),
        .snooze(snooze), .stop(stop),
        .al_h1(al_h1), .al_h0(al_h0), .al_m1(al_m1), .al_m0(al_m0),
        .ringing(ringing), .snoozed(snoozed), .buzz(buzz)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] bcd(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    // bz < 0 means the tone phase is not checked for this entry
    task automatic push(input string name, input logic r, input logic s, input int bz);
        exp_t e;
        e.name = name; e.al = bcd(mh, mm); e.ring = r; e.snz = s; e.bz = bz;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge mclk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.name, " al"}, {al_h1, al_h0, al_m1, al_m0}, e.al);
            if (e.bz < 0)
                chk({e.name, " ring/snz"}, {14'd0, ringing, snoozed}, {14'd0, e.ring, e.snz});
            else
                chk({e.name, " ring/snz/buzz"}, {13'd0, ringing, snoozed, buzz},
                    {13'd0, e.ring, e.snz, 1'(e.bz)});
        end
        tick = 1'b0; inc_h = 1'b0; inc_m = 1'b0; snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic do_tick(input int h, input int m, input int s);
        h_1 = 4'(h / 10); h_0 = 4'(h % 10);
        m_1 = 4'(m / 10); m_0 = 4'(m % 10);
        s_1 = 4'(s / 10); s_0 = 4'(s % 10);
        tick = 1'b1;
    endtask

    task automatic enter_ring(input string name);
        do_tick(mh, mm, 0);
        push(name, 1'b1, 1'b0, 0);
        cyc();
    endtask

    task automatic step_h(input int n);
        for (int i = 0; i < n; i++) begin
            inc_h = 1'b1;
            mh = (mh + 1) % 12;
            push($sformatf("inc_h to %0d", mh), 1'b0, 1'b0, 0);
            cyc();
        end
    endtask

    task automatic step_m(input int n);
        for (int i = 0; i < n; i++) begin
            inc_m = 1'b1;
            mm = (mm + 1) % 60;
            push($sformatf("inc_m to %0d", mm), 1'b0, 1'b0, 0);
            cyc();
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0100};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 16'h0101};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 16'h0101};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 16'h0202};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h0202};

        #1 rst = 1'b0;
        #10;
        chk("reset al", {al_h1, al_h0, al_m1, al_m0}, 16'h0000);
        chk("reset outs", {13'd0, ringing, snoozed, buzz}, 16'h0000);
        @(negedge mclk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            exp_t e;
            set_mode = tbl[i].sm; inc_h = tbl[i].ih; inc_m = tbl[i].im;
            e.name = $sformatf("tbl%0d", i); e.al = tbl[i].al;
            e.ring = 1'b0; e.snz = 1'b0; e.bz = 0;
            sb_q.push_back(e);
            cyc();
        end

        // async reset clears the alarm time, then wrap both fields
        #1 rst = 1'b0;
        #1 chk("async reset al", {al_h1, al_h0, al_m1, al_m0}, 16'h0000);
        rst = 1'b1;
        mh = 0; mm = 0;
        set_mode = 1'b1;
        step_h(13);
        step_m(61);
        chk("wrap 13h 61m", {al_h1, al_h0, al_m1, al_m0}, 16'h0101);
        step_h(6);
        step_m(29);
        set_mode = 1'b0;

        // match ticks that must not ring
        alarm_on = 1'b0; do_tick(7, 30, 0); push("unarmed match", 1'b0, 1'b0, 0); cyc();
        alarm_on = 1'b1; set_mode = 1'b1; do_tick(7, 30, 0);
        push("set_mode match", 1'b0, 1'b0, 0); cyc();
        set_mode = 1'b0;
        do_tick(7, 30, 1); push("secs nonzero", 1'b0, 1'b0, 0); cyc();
        do_tick(7, 31, 0); push("minute off", 1'b0, 1'b0, 0); cyc();

        // ring, tone phase, then timeout (a re-match mid ring must not restart)
        enter_ring("ring entry");
        for (int k = 1; k <= 2 * BH; k++) begin
            push($sformatf("tone k=%0d", k), 1'b1, 1'b0, (k / BH) % 2);
            cyc();
        end
        for (int i = 1; i <= RS; i++) begin
            if (i == 2) do_tick(7, 30, 0); else do_tick(7, 31, i);
            push($sformatf("ring tick %0d", i), i < RS, 1'b0, (i < RS) ? -1 : 0);
            cyc();
        end

        // snooze, ignored second snooze, snooze expiry
        enter_ring("ring2 entry");
        snooze = 1'b1;
`ifdef ALARM_SNOOZE_EN
        push("snooze", 1'b0, 1'b1, 0); cyc();
        snooze = 1'b1; push("snooze again", 1'b0, 1'b1, 0); cyc();
        for (int i = 1; i <= SS; i++) begin
            do_tick(7, 32, i);
            push($sformatf("snz tick %0d", i), i == SS, i < SS, (i == SS) ? 0 : -1);
            cyc();
        end
`else
        push("snooze ignored", 1'b1, 1'b0, -1); cyc();
        snooze = 1'b1; push("snooze again", 1'b1, 1'b0, -1); cyc();
        for (int i = 1; i <= SS; i++) begin
            do_tick(7, 32, i);
            push($sformatf("snz tick %0d", i), 1'b1, 1'b0, -1);
            cyc();
        end
`endif
        stop = 1'b1; snooze = 1'b1; push("stop+snooze", 1'b0, 1'b0, 0); cyc();

        // alarm_on drop while snoozed (or ringing)
        enter_ring("ring3 entry");
        snooze = 1'b1;
`ifdef ALARM_SNOOZE_EN
        push("snooze3", 1'b0, 1'b1, 0);
`else
        push("snooze3", 1'b1, 1'b0, -1);
`endif
        cyc();
        alarm_on = 1'b0; push("disarm", 1'b0, 1'b0, 0); cyc();
        alarm_on = 1'b1;

        // snooze outranks a simultaneous ring timeout
        enter_ring("ring4 entry");
        for (int i = 1; i < RS; i++) begin
            do_tick(7, 33, i);
            push($sformatf("ring4 tick %0d", i), 1'b1, 1'b0, -1);
            cyc();
        end
        do_tick(7, 33, RS); snooze = 1'b1;
`ifdef ALARM_SNOOZE_EN
        push("snooze vs timeout", 1'b0, 1'b1, 0);
`else
        push("snooze vs timeout", 1'b0, 1'b0, 0);
`endif
        cyc();
        stop = 1'b1; push("stop", 1'b0, 1'b0, 0); cyc();

        // set_mode aborts a ring
        enter_ring("ring5 entry");
        set_mode = 1'b1; push("set_mode abort", 1'b0, 1'b0, 0); cyc();
        set_mode = 1'b0;

        // asynchronous reset mid ring with buzz high
        enter_ring("ring6 entry");
        for (int k = 1; k <= BH + 1; k++) begin
            push($sformatf("ring6 k=%0d", k), 1'b1, 1'b0, (k / BH) % 2);
            cyc();
        end
        #2 rst = 1'b0;
        #1;
        chk("mid-ring reset al", {al_h1, al_h0, al_m1, al_m0}, 16'h0000);
        chk("mid-ring reset outs", {13'd0, ringing, snoozed, buzz}, 16'h0000);
        mh = 0; mm = 0;

        // first edge after reset release can start a ring
        @(negedge mclk);
        rst = 1'b1;
        do_tick(0, 0, 0);
        push("first edge ring", 1'b1, 1'b0, 0);
        cyc();
        stop = 1'b1; push("final stop", 1'b0, 1'b0, 0); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
